// File: rtl/mem_master_pkg.sv
// rtl/mem_master_pkg.sv - shared widths, state encoding and wrap constant for mem_master
package mem_master_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 20;
    localparam int LEN_W  = 4;

    localparam logic [ADDR_W-1:0] ADDR_WRAP = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/mem_master_addr_gen.sv
// rtl/mem_master_addr_gen.sv - address register with wrap plus beat down-counter (MEM_MASTER_BURST_EN)
import mem_master_pkg::*;

module mem_master_addr_gen (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    // Address register: loaded on accept, stepped once per read beat, wraps at the top word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_addr;
        end else if (inc) begin
            addr <= (addr == ADDR_WRAP) ? '0 : addr + ADDR_W'(1);
        end
    end

`ifdef MEM_MASTER_BURST_EN
    logic [LEN_W-1:0] cnt;

    // Remaining beats after the current one; zero marks the final issue cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_len;
        end else if (inc) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    assign last = (cnt == '0);
`else
    // Single-beat reads only: every issue cycle is the last one
    logic unused_len;
    assign unused_len = ^load_len;
    assign last       = 1'b1;
`endif

endmodule

// File: rtl/mem_master.sv
// rtl/mem_master.sv - request sequencer for the 32K x 20 word memory; burst reads under MEM_MASTER_BURST_EN
import mem_master_pkg::*;

module mem_master (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_do
);

    state_t state;
    logic   accept;
    logic   last;

    assign accept    = (state == IDLE) && req_valid && req_ready;
    assign rsp_rdata = mem_do;

    mem_master_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .inc       ((state == READ) && !last),
        .load_addr (req_addr),
        .load_len  (req_len),
        .addr      (mem_addr),
        .last      (last)
    );

    // Sequencer FSM with registered strobes; the response pipeline trails mem_re by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_di    <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            rsp_valid <= mem_re;
            rsp_last  <= mem_re && last;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_we) begin
                            state  <= WRITE;
                            mem_we <= 1'b1;
                            mem_di <= req_wdata;
                        end else begin
                            state  <= READ;
                            mem_re <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    mem_we    <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                READ: begin
                    if (last) begin
                        mem_re <= 1'b0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
